// File: rtl/adder_operand_stage.sv
// Operand stage feeding the 32-bit carry-lookahead adder.
// Captures decoded operands, applies writeback forwarding, immediate
// extension and add/sub conditioning, then presents the result through a
// 2-entry skid buffer (head register drives the outputs, skid holds one more).
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   flush             discard all buffered entries (and any same-cycle accept)
//   in_valid/in_ready upstream handshake; in_ready depends on state only
//   in_rs*_idx/data   source register indices and register file read data
//   in_imm            immediate field, extended per in_sign_ext when in_use_imm
//   in_sub            1: subtract (roperand inverted, cin=1)
//   fwd_valid/idx/data writeback forwarding port, applied at capture only
//   out_valid/out_ready downstream handshake
//   out_loperand/out_roperand/out_cin  adder operands, consumed unmodified
module adder_operand_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IMM_WIDTH = 16,
  parameter int unsigned IDX_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDX_WIDTH-1:0] in_rs1_idx,
  input  logic [IDX_WIDTH-1:0] in_rs2_idx,
  input  logic [WIDTH-1:0]     in_rs1_data,
  input  logic [WIDTH-1:0]     in_rs2_data,
  input  logic [IMM_WIDTH-1:0] in_imm,
  input  logic                 in_use_imm,
  input  logic                 in_sign_ext,
  input  logic                 in_sub,
  input  logic                 fwd_valid,
  input  logic [IDX_WIDTH-1:0] fwd_idx,
  input  logic [WIDTH-1:0]     fwd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_loperand,
  output logic [WIDTH-1:0]     out_roperand,
  output logic                 out_cin
);

  localparam int unsigned EXT_WIDTH = WIDTH - IMM_WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;

  logic [WIDTH-1:0] skid_loperand;
  logic [WIDTH-1:0] skid_roperand;
  logic             skid_cin;

  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b_reg;
  logic [WIDTH-1:0] cap_imm;
  logic [WIDTH-1:0] cap_b;
  logic [WIDTH-1:0] cap_roperand;
  logic             cap_cin;
  logic             accept;
  logic             emit;

  // Handshake status is a pure decode of the registered state.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  // Capture-time operand formation: forwarding, immediate extension, sub conditioning.
  always_comb begin
    cap_a        = in_rs1_data;
    cap_b_reg    = in_rs2_data;
    cap_imm      = {{EXT_WIDTH{in_sign_ext & in_imm[IMM_WIDTH-1]}}, in_imm};
    cap_b        = cap_b_reg;
    cap_roperand = '0;
    cap_cin      = 1'b0;

    // Register 0 is hardwired, so a writeback targeting it is never forwarded.
    if (fwd_valid && (fwd_idx == in_rs1_idx) && (in_rs1_idx != '0)) begin
      cap_a = fwd_data;
    end
    if (fwd_valid && (fwd_idx == in_rs2_idx) && (in_rs2_idx != '0)) begin
      cap_b_reg = fwd_data;
    end

    cap_b        = in_use_imm ? cap_imm : cap_b_reg;
    cap_roperand = in_sub ? ~cap_b : cap_b;
    cap_cin      = in_sub;
  end

  // Skid-buffer control and storage; head register is the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EMPTY;
      out_loperand  <= '0;
      out_roperand  <= '0;
      out_cin       <= 1'b0;
      skid_loperand <= '0;
      skid_roperand <= '0;
      skid_cin      <= 1'b0;
    end else if (flush) begin
      // Head data is left in place; out_valid=0 marks it as not to be sampled.
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_loperand <= cap_a;
            out_roperand <= cap_roperand;
            out_cin      <= cap_cin;
            state        <= ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            out_loperand <= cap_a;
            out_roperand <= cap_roperand;
            out_cin      <= cap_cin;
            state        <= ONE;
          end else if (accept) begin
            skid_loperand <= cap_a;
            skid_roperand <= cap_roperand;
            skid_cin      <= cap_cin;
            state         <= FULL;
          end else if (emit) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            out_loperand  <= skid_loperand;
            out_roperand  <= skid_roperand;
            out_cin       <= skid_cin;
            skid_loperand <= '0;
            skid_roperand <= '0;
            skid_cin      <= 1'b0;
            state         <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_operand_stage.sv
module tb_adder_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_idx;
  logic [4:0]  in_rs2_idx;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [15:0] in_imm;
  logic        in_use_imm;
  logic        in_sign_ext;
  logic        in_sub;
  logic        fwd_valid;
  logic [4:0]  fwd_idx;
  logic [31:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_loperand;
  logic [31:0] out_roperand;
  logic        out_cin;

  always #5 clk = ~clk;

  adder_operand_stage #(.WIDTH(32), .IMM_WIDTH(16), .IDX_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_sign_ext(in_sign_ext), .in_sub(in_sub),
    .fwd_valid(fwd_valid), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_loperand(out_loperand), .out_roperand(out_roperand), .out_cin(out_cin)
  );

  typedef struct {
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [15:0] imm;
    logic        use_imm;
    logic        sign_ext;
    logic        sub;
    logic        fwd_valid;
    logic [4:0]  fwd_idx;
    logic [31:0] fwd_data;
  } bundle_t;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic        c;
  } result_t;

  typedef struct {
    string   name;
    bundle_t b;
    result_t exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bundle_t b);
    in_rs1_idx  = b.rs1_idx;
    in_rs2_idx  = b.rs2_idx;
    in_rs1_data = b.rs1_data;
    in_rs2_data = b.rs2_data;
    in_imm      = b.imm;
    in_use_imm  = b.use_imm;
    in_sign_ext = b.sign_ext;
    in_sub      = b.sub;
    fwd_valid   = b.fwd_valid;
    fwd_idx     = b.fwd_idx;
    fwd_data    = b.fwd_data;
  endtask

  // Reference: operand formation computed directly from the architectural rules.
  function automatic result_t model(input bundle_t b);
    result_t     r;
    logic [31:0] bv;
    int signed   simm;
    r.l = (b.fwd_valid && b.rs1_idx != 0 && b.fwd_idx == b.rs1_idx) ? b.fwd_data : b.rs1_data;
    if (b.use_imm) begin
      simm = $signed(b.imm);
      bv   = b.sign_ext ? 32'(simm) : 32'(int'(b.imm));
    end else begin
      bv = (b.fwd_valid && b.rs2_idx != 0 && b.fwd_idx == b.rs2_idx) ? b.fwd_data : b.rs2_data;
    end
    // Subtraction as a + (-b) = a + ~b + 1.
    r.r = b.sub ? (32'hFFFF_FFFF - bv) : bv;
    r.c = b.sub;
    return r;
  endfunction

  function automatic bundle_t mk(input logic [31:0] rs1, input logic [31:0] rs2);
    bundle_t b;
    b = '{rs1_idx: 5'd1, rs2_idx: 5'd2, rs1_data: rs1, rs2_data: rs2, imm: 16'h0,
          use_imm: 1'b0, sign_ext: 1'b0, sub: 1'b0, fwd_valid: 1'b0, fwd_idx: 5'd0,
          fwd_data: 32'h0};
    return b;
  endfunction

  task automatic chk_head(input string name, input logic [31:0] l, input logic [31:0] r,
                          input logic c);
    chk({name, ".valid"}, 32'(out_valid), 32'd1);
    chk({name, ".l"}, out_loperand, l);
    chk({name, ".r"}, out_roperand, r);
    chk({name, ".cin"}, 32'(out_cin), 32'(c));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t    vecs[$];
  bundle_t q_model[$];
  bundle_t bx, by, bz, bw, bv;
  result_t er;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(mk(32'h0, 32'h0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.l", out_loperand, 32'h0);
    chk("rst.r", out_roperand, 32'h0);
    chk("rst.cin", 32'(out_cin), 32'd0);

    // Directed vector table with hand-derived expectations
    vecs.push_back('{"add_rr",   '{5'd1, 5'd2, 32'h5, 32'h3, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0},
                     '{32'h5, 32'h3, 1'b0}});
    vecs.push_back('{"sub_sext", '{5'd1, 5'd2, 32'h10, 32'h0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0},
                     '{32'h10, 32'h0000_0000, 1'b1}});
    vecs.push_back('{"sub_zext", '{5'd1, 5'd2, 32'h10, 32'h0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0},
                     '{32'h10, 32'hFFFF_0000, 1'b1}});
    vecs.push_back('{"fwd_rs1",  '{5'd7, 5'd3, 32'h1, 32'h2, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF},
                     '{32'hDEAD_BEEF, 32'h2, 1'b0}});
    vecs.push_back('{"fwd_idx0", '{5'd0, 5'd3, 32'h1, 32'h2, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF},
                     '{32'h1, 32'h2, 1'b0}});
    vecs.push_back('{"fwd_rs2",  '{5'd4, 5'd9, 32'h20, 32'h7, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h100},
                     '{32'h20, 32'hFFFF_FEFF, 1'b1}});
    vecs.push_back('{"imm_pos",  '{5'd1, 5'd2, 32'h3, 32'h9, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0},
                     '{32'h3, 32'h0000_7FFF, 1'b0}});
    vecs.push_back('{"fwd_off",  '{5'd7, 5'd2, 32'h11, 32'h22, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'hCAFE},
                     '{32'h11, 32'h22, 1'b0}});
    vecs.push_back('{"imm_over", '{5'd1, 5'd6, 32'h4, 32'h55, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'h99},
                     '{32'h4, 32'hFFFF_8000, 1'b0}});

    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].b);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk_head(vecs[i].name, vecs[i].exp.l, vecs[i].exp.r, vecs[i].exp.c);
      @(posedge clk);
      @(negedge clk);
      chk({vecs[i].name, ".drain"}, 32'(out_valid), 32'd0);
    end

    // Backpressure: X, Y buffered, Z stalled, then drained in order
    bx = mk(32'hA1, 32'h1); by = mk(32'hB2, 32'h2); bz = mk(32'hC3, 32'h3);
    out_ready = 1'b0;
    drive(bx); in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_head("bp.x", 32'hA1, 32'h1, 1'b0);
    chk("bp.ready1", 32'(in_ready), 32'd1);
    drive(by);
    @(posedge clk); @(negedge clk);
    chk("bp.ready_full", 32'(in_ready), 32'd0);
    drive(bz);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk_head("bp.x_hold", 32'hA1, 32'h1, 1'b0);
      chk("bp.stall", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_head("bp.y", 32'hB2, 32'h2, 1'b0);
    chk("bp.ready_one", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk_head("bp.z", 32'hC3, 32'h3, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Flush while FULL with a same-cycle in_valid
    out_ready = 1'b0;
    drive(mk(32'h111, 32'h0)); in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    drive(mk(32'h222, 32'h0));
    @(posedge clk); @(negedge clk);
    chk("fl.full", 32'(in_ready), 32'd0);
    bw = mk(32'h333, 32'h0);
    drive(bw); flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl.valid", 32'(out_valid), 32'd0);
    chk("fl.ready", 32'(in_ready), 32'd1);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("fl.no_emit", 32'(out_valid), 32'd0);
    end
    bv = mk(32'h444, 32'h5);
    drive(bv); in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk_head("fl.after", 32'h444, 32'h5, 1'b0);
    @(posedge clk); @(negedge clk);

    // Reset while ONE with out_ready low
    out_ready = 1'b0;
    bv = mk(32'h5555, 32'h6666); bv.sub = 1'b1;
    drive(bv); in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk_head("rs.one", 32'h5555, 32'hFFFF_999A - 32'h1, 1'b1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rs.valid", 32'(out_valid), 32'd0);
    chk("rs.ready", 32'(in_ready), 32'd1);
    chk("rs.l", out_loperand, 32'h0);
    chk("rs.r", out_roperand, 32'h0);
    chk("rs.cin", 32'(out_cin), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rs.no_emit", 32'(out_valid), 32'd0);

    // Random traffic against a FIFO-of-bundles reference
    do_reset();
    q_model.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd.valid", 32'(out_valid), 32'(q_model.size() > 0));
      chk("rnd.ready", 32'(in_ready), 32'(q_model.size() < 2));
      if (q_model.size() > 0) begin
        er = model(q_model[0]);
        chk("rnd.l", out_loperand, er.l);
        chk("rnd.r", out_roperand, er.r);
        chk("rnd.cin", 32'(out_cin), 32'(er.c));
      end
      bv.rs1_idx   = 5'($urandom_range(0, 3));
      bv.rs2_idx   = 5'($urandom_range(0, 3));
      bv.rs1_data  = $urandom;
      bv.rs2_data  = $urandom;
      bv.imm       = 16'($urandom);
      bv.use_imm   = 1'($urandom);
      bv.sign_ext  = 1'($urandom);
      bv.sub       = 1'($urandom);
      bv.fwd_valid = 1'($urandom);
      bv.fwd_idx   = 5'($urandom_range(0, 3));
      bv.fwd_data  = $urandom;
      drive(bv);
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 4);
      rst       = ($urandom_range(0, 199) < 2);
      @(posedge clk);
      if (rst || flush) begin
        q_model.delete();
      end else begin
        bit can_take;
        can_take = (q_model.size() < 2);
        if (out_ready && q_model.size() > 0) void'(q_model.pop_front());
        if (in_valid && can_take) q_model.push_back(bv);
      end
      @(negedge clk);
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
